// File: rtl/alu_pkg.sv
// Shared types for the ALU status/output stage: beat layout, flag struct and
// the saturating helper used by the optional zero-result counter.
package alu_pkg;

  localparam int ALU_DATA_W = 128;
  localparam int ZCOUNT_W   = 16;

  typedef struct packed {
    logic o;
    logic c;
    logic z;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [2:0]            opsel;
    logic                  mode;
    alu_flags_t            flags;
  } alu_beat_t;

  function automatic logic [ZCOUNT_W-1:0] sat_inc(input logic [ZCOUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a registered input ready.
// Output data comes straight from the head register and holds its value when empty.
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic [1:0]   r_count;
  logic         r_in_ready;
  logic         r_out_valid;

  logic         w_acc;
  logic         w_del;
  logic [1:0]   w_count_nxt;

  assign w_acc = i_valid && r_in_ready;
  assign w_del = r_out_valid && i_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_acc && !w_del)
      w_count_nxt = r_count + 2'd1;
    else if (!w_acc && w_del)
      w_count_nxt = r_count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_skid      <= '0;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      // Head loads the incoming beat only when it would otherwise be empty;
      // a full buffer that delivers promotes the skid entry instead.
      if (w_acc && ((r_count == 2'd0) || (w_del && r_count == 2'd1)))
        r_head <= i_data;
      else if (w_del && r_count == 2'd2)
        r_head <= r_skid;
      if (w_acc && ((r_count == 2'd1 && !w_del) || (r_count == 2'd2 && w_del)))
        r_skid <= i_data;
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_head;

endmodule

// File: rtl/alu_status_reg.sv
// ALU output stage: skid-buffers ALU beats toward writeback and accumulates sticky flags.
// Optional macro ZCOUNT_EN adds a saturating count of accepted beats with z=1.
module alu_status_reg
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [2:0]        in_opsel,
  input  logic              in_mode,
  input  logic [2:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [2:0]        out_opsel,
  output logic              out_mode,
  output logic [2:0]        out_flags,
  input  logic              clr_sticky,
  output logic [2:0]        sticky_flags
`ifdef ZCOUNT_EN
  ,
  output logic [ZCOUNT_W-1:0] zcount
`endif
);

  if (DATA_W != ALU_DATA_W || DEPTH != 2) begin : g_bad_cfg
    $error("alu_status_reg supports only DATA_W=128 and DEPTH=2");
  end

  alu_beat_t  w_in_beat;
  alu_beat_t  w_out_beat;
  logic       w_acc;
  logic [2:0] r_sticky;

  assign w_in_beat = {in_result, in_opsel, in_mode, in_flags};
  assign w_acc     = in_valid && in_ready;

  alu_skid_buf #(
    .W($bits(alu_beat_t))
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_beat),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_beat)
  );

  assign out_result = w_out_beat.result;
  assign out_opsel  = w_out_beat.opsel;
  assign out_mode   = w_out_beat.mode;
  assign out_flags  = w_out_beat.flags;

  // Clear is applied before OR-ing in the current beat so it survives a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)
      r_sticky <= 3'b000;
    else
      r_sticky <= (clr_sticky ? 3'b000 : r_sticky) | (w_acc ? in_flags : 3'b000);
  end

  assign sticky_flags = r_sticky;

`ifdef ZCOUNT_EN
  logic [ZCOUNT_W-1:0] r_zcount;
  logic [ZCOUNT_W-1:0] w_zbase;

  assign w_zbase = clr_sticky ? '0 : r_zcount;

  always_ff @(posedge clk) begin
    if (rst)
      r_zcount <= '0;
    else if (w_acc && in_flags[0])
      r_zcount <= sat_inc(w_zbase);
    else
      r_zcount <= w_zbase;
  end

  assign zcount = r_zcount;
`endif

endmodule

// File: tb/tb_alu_status_reg.sv
// Bench for alu_status_reg: scoreboard on beat order plus table and hand-written
// sequences for sticky flags, back-pressure, streaming and reset.
module tb_alu_status_reg;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_result;
  logic [2:0]        in_opsel;
  logic              in_mode;
  logic [2:0]        in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_result;
  logic [2:0]        out_opsel;
  logic              out_mode;
  logic [2:0]        out_flags;
  logic              clr_sticky;
  logic [2:0]        sticky_flags;
`ifdef ZCOUNT_EN
  logic [ZCOUNT_W-1:0] zcount;
`endif

  always #5 clk = ~clk;

  alu_status_reg dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_opsel     (in_opsel),
    .in_mode      (in_mode),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_opsel    (out_opsel),
    .out_mode     (out_mode),
    .out_flags    (out_flags),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags)
`ifdef ZCOUNT_EN
    ,
    .zcount       (zcount)
`endif
  );

  int        n_cmp = 0;
  int        n_bad = 0;
  int        cyc   = 0;
  alu_beat_t sb_q[$];
  alu_beat_t sb_exp;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input alu_beat_t act, input alu_beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: handshakes are judged on the negedge, where inputs and
  // registered outputs are stable for the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got beat %0h expected none", out_result);
        end else begin
          sb_exp = sb_q.pop_front();
          chk_beat("sb_beat", {out_result, out_opsel, out_mode, out_flags}, sb_exp);
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back({in_result, in_opsel, in_mode, in_flags});
    end
  end

  function automatic alu_beat_t mk(input int i, input logic [2:0] f);
    alu_beat_t b;
    b.result = {4{32'hA500_0000 | 32'(i)}};
    b.opsel  = 3'(i);
    b.mode   = i[0];
    b.flags  = f;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_beat_t b);
    {in_result, in_opsel, in_mode, in_flags} = b;
  endtask

  // Holds the beat until accepted; returns after the accepting edge.
  task automatic send(input alu_beat_t b);
    int k;
    drive(b);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic       clr;
    logic       vld;
    logic [2:0] flags;
    logic [2:0] exp_sticky;
  } vec_t;

  vec_t      vecs[8];
  alu_beat_t ba, bb, bc, b0;
  int        t0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'b000, 3'b000};
    vecs[1] = '{1'b0, 1'b1, 3'b001, 3'b001};
    vecs[2] = '{1'b0, 1'b1, 3'b100, 3'b101};
    vecs[3] = '{1'b0, 1'b0, 3'b010, 3'b101};
    vecs[4] = '{1'b1, 1'b1, 3'b010, 3'b010};
    vecs[5] = '{1'b0, 1'b1, 3'b000, 3'b010};
    vecs[6] = '{1'b1, 1'b0, 3'b111, 3'b000};
    vecs[7] = '{1'b0, 1'b1, 3'b111, 3'b111};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    drive(mk(0, 3'b000));
    repeat (3) step();
    rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_sticky", 64'(sticky_flags), 64'd0);

    // single beat into empty buffer
    b0 = '0;
    b0.flags = 3'b001;
    send(b0);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_flags", 64'(out_flags), 64'd1);
    chk("lat_sticky", 64'(sticky_flags), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lat_drained", 64'(out_valid), 64'd0);

    // sticky table
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clr_sticky = vecs[i].clr;
      drive(mk(10 + i, vecs[i].flags));
      in_valid = vecs[i].vld;
      step();
      in_valid = 1'b0;
      clr_sticky = 1'b0;
      chk($sformatf("sticky_vec%0d", i), 64'(sticky_flags), 64'(vecs[i].exp_sticky));
    end
    step();
    out_ready = 1'b0;

    // back-pressure: A,B stored, C held by source
    ba = mk(21, 3'b001); bb = mk(22, 3'b010); bc = mk(23, 3'b100);
    drive(ba); in_valid = 1'b1;
    step();
    chk("bp_ready_after_a", 64'(in_ready), 64'd1);
    drive(bb);
    step();
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(out_result), 64'(ba.result));
    drive(bc);
    repeat (2) step();
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk_beat("bp_head_stable", {out_result, out_opsel, out_mode, out_flags}, ba);
    out_ready = 1'b1;
    step();
    chk("bp_slot_freed", 64'(in_ready), 64'd1);
    chk("bp_head_b", 64'(out_result), 64'(bb.result));
    step();
    in_valid = 1'b0;
    chk("bp_head_c", 64'(out_result), 64'(bc.result));
    step();
    out_ready = 1'b0;
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_data_hold", 64'(out_result), 64'(bc.result));

    // full buffer then continuous accept+deliver for 10 beats
    send(mk(30, 3'b000));
    send(mk(31, 3'b001));
    chk("str_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) send(mk(40 + i, 3'(i)));
    chk("str_cycles", 64'(cyc - t0), 64'd11);
    chk("str_valid", 64'(out_valid), 64'd1);
    step();
    chk("str_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // reset with two beats buffered
    send(mk(50, 3'b111));
    send(mk(51, 3'b011));
    chk("rb_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    chk("rb_out_valid", 64'(out_valid), 64'd0);
    chk("rb_in_ready", 64'(in_ready), 64'd1);
    chk("rb_sticky", 64'(sticky_flags), 64'd0);
    chk("rb_out_result", 64'(out_result), 64'd0);
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    send(mk(52, 3'b010));
    step();
    chk("rb_post_empty", 64'(out_valid), 64'd0);

`ifdef ZCOUNT_EN
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("zc_cleared", 64'(zcount), 64'd0);
    send(mk(60, 3'b001));
    send(mk(61, 3'b011));
    send(mk(62, 3'b000));
    send(mk(63, 3'b101));
    chk("zc_three", 64'(zcount), 64'd3);
    clr_sticky = 1'b1;
    send(mk(64, 3'b001));
    clr_sticky = 1'b0;
    chk("zc_clr_acc", 64'(zcount), 64'd1);
    drive(mk(65, 3'b001));
    in_valid = 1'b1;
    repeat (65540) step();
    in_valid = 1'b0;
    chk("zc_sat", 64'(zcount), 64'hFFFF);
    send(mk(66, 3'b001));
    chk("zc_sat_hold", 64'(zcount), 64'hFFFF);
`endif

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
